// File: rtl/demux_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_dispatch_if
// Description : Bundles the demux_dispatch word streams. One valid/ready
//               input stream carries a word and a destination address.
//               Four valid/ready output channels each present their head
//               word.
//
//               Signals (the slave modport shows the dispatcher's view):
//                 in_valid   producer offers a word
//                 in_ready   dispatcher accepts it this cycle
//                 in_addr    destination channel 0..3
//                 in_data    the word, WIDTH bits
//                 in_bcast   push to all channels (DEMUX_BROADCAST_EN only)
//                 out_valid  bit k: channel k head valid
//                 out_ready  bit k: channel k consumer takes its head
//                 out_data0..3  head word of each channel
//                 busy       any channel holds a word
//
//               Optional feature macro: DEMUX_BROADCAST_EN
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_dispatch_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_addr;
    logic [WIDTH-1:0] in_data;
`ifdef DEMUX_BROADCAST_EN
    logic             in_bcast;
`endif
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic             busy;

    // Dispatcher side
    modport slave (
`ifdef DEMUX_BROADCAST_EN
        input  in_bcast,
`endif
        input  in_valid,
        input  in_addr,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data0,
        output out_data1,
        output out_data2,
        output out_data3,
        output busy
    );

    // Producer / consumer side
    modport master (
`ifdef DEMUX_BROADCAST_EN
        output in_bcast,
`endif
        output in_valid,
        output in_addr,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data0,
        input  out_data1,
        input  out_data2,
        input  out_data3,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/demux_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : demux_dispatch
// Description : Routes one valid/ready word stream to one of four output
//               channels, selected by a 2-bit address. Each channel owns a
//               2-entry FIFO, so a stalled consumer only blocks words aimed
//               at its own channel.
//
//               Ports:
//                 clk    single clock, all state on the rising edge
//                 rst_n  synchronous reset, active low
//                 bus    demux_dispatch_if.slave (see interface header)
//
//               Optional feature macro: DEMUX_BROADCAST_EN
//                 When defined, in_bcast=1 pushes an accepted word into all
//                 four FIFOs at once and in_addr is ignored. The word is
//                 accepted only when no FIFO is full.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_dispatch #(
    parameter int WIDTH = 16
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    demux_dispatch_if.slave  bus
);

    localparam logic [1:0] c_cnt_full  = 2'd2;
    localparam logic [1:0] c_cnt_empty = 2'd0;

    logic [3:0]       w_full;
    logic [3:0]       w_nonempty;
    logic [3:0]       w_push;
    logic [3:0]       w_pop;
    logic [WIDTH-1:0] w_head [4];
    logic             w_ready;
    logic             w_accept;

    // ------------------------------------------------------------------
    // Input acceptance. Ready depends only on registered counts and the
    // reset, so no combinational path exists from out_ready to in_ready.
    // ------------------------------------------------------------------
`ifdef DEMUX_BROADCAST_EN
    assign w_ready = rst_n && (bus.in_bcast ? (w_full == 4'b0000)
                                            : !w_full[bus.in_addr]);
`else
    assign w_ready = rst_n && !w_full[bus.in_addr];
`endif

    assign w_accept = bus.in_valid && w_ready;

    // ------------------------------------------------------------------
    // Per-channel 2-entry FIFO
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 4; k++) begin : g_ch
        logic [1:0]       r_cnt;
        logic             r_rd_ptr;
        logic             r_wr_ptr;
        logic [WIDTH-1:0] r_mem [2];
        logic             w_sel;

`ifdef DEMUX_BROADCAST_EN
        assign w_sel = bus.in_bcast || (bus.in_addr == 2'(k));
`else
        assign w_sel = (bus.in_addr == 2'(k));
`endif

        assign w_full[k]     = (r_cnt == c_cnt_full);
        assign w_nonempty[k] = (r_cnt != c_cnt_empty);
        assign w_push[k]     = w_accept && w_sel;
        // A pop needs a valid head, so an empty FIFO never pops even
        // when a same-edge push is filling it.
        assign w_pop[k]      = w_nonempty[k] && bus.out_ready[k];
        assign w_head[k]     = r_mem[r_rd_ptr];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt    <= c_cnt_empty;
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
                r_mem[0] <= '0;
                r_mem[1] <= '0;
            end else begin
                if (w_push[k]) begin
                    r_mem[r_wr_ptr] <= bus.in_data;
                    r_wr_ptr        <= ~r_wr_ptr;
                end
                if (w_pop[k]) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                // Push into a full FIFO is blocked by ready, so the
                // count never leaves 0..2.
                case ({w_push[k], w_pop[k]})
                    2'b10:   r_cnt <= r_cnt + 2'd1;
                    2'b01:   r_cnt <= r_cnt - 2'd1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all taken from registered state
    // ------------------------------------------------------------------
    assign bus.in_ready  = w_ready;
    assign bus.out_valid = w_nonempty;
    assign bus.busy      = |w_nonempty;
    assign bus.out_data0 = w_head[0];
    assign bus.out_data1 = w_head[1];
    assign bus.out_data2 = w_head[2];
    assign bus.out_data3 = w_head[3];

endmodule
`default_nettype wire
